lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Arbitrates one shared single-ported LC-3 memory between the fetch stage (instruction port) and the execute/memory stage (data port: LD/LDR/LDI/ST/STR/STI phases).
- Registers each accepted request, holds it on the memory port until the memory's completion handshake, then returns a one-cycle response to the owner.
- Data requests have priority; a streak limit prevents fetch starvation.
- Supports flushing an in-flight fetch on branch/jump.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while an instruction request waits; then instruction wins.
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack before abort. Used only with LC3_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ireq_valid  in  1  fetch request
- ireq_addr  in  16  fetch address (PC)
- ireq_ready  out  1  fetch request accepted this cycle (combinational)
- irsp_valid  out  1  fetch data valid, one-cycle pulse
- irsp_data  out  16  fetched instruction
- iflush  in  1  discard the in-flight or next fetch response (branch taken)
- dreq_valid  in  1  data request
- dreq_we  in  1  1 = write, 0 = read
- dreq_addr  in  16  data address
- dreq_wdata  in  16  write data
- dreq_ready  out  1  data request accepted this cycle (combinational)
- drsp_valid  out  1  data read or write complete, one-cycle pulse
- drsp_data  out  16  read data
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- busy  out  1  state is not IDLE
- mem_err  out  1  timeout pulse; constant 0 without the macro

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, irsp_valid, drsp_valid, mem_err = 0; mem_addr, mem_wdata, irsp_data, drsp_data = 16'h0000; streak = 0; flush_pend = 0.
- States:
  - IDLE: no transaction in progress.
  - I_BUSY: fetch transaction on the memory port.
  - D_BUSY: data transaction on the memory port.
- Ready outputs:
  - ireq_ready and dreq_ready are asserted only in IDLE, and only to the arbitration winner.
  - At most one ready is high per cycle.
- Arbitration in IDLE:
  - Only one valid: that port wins.
  - Both valid: data wins unless streak == MAX_DATA_STREAK, in which case instruction wins.
- Streak counter:
  - Increments (saturating) on a data grant while ireq_valid = 1.
  - Clears on an instruction grant, or on a data grant while ireq_valid = 0.
- Acceptance at edge T: latch address, we and wdata into mem_addr/mem_we/mem_wdata; set mem_req = 1; enter I_BUSY or D_BUSY. Instruction grants force mem_we = 0.
- Busy states:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - At the edge sampling mem_ack: mem_req goes 0 and the state returns to IDLE.
  - The port's rsp_valid pulses in the following cycle.
  - Minimum latency is accept at T, mem_ack at T+1, rsp_valid at T+2.
  - A new request can be accepted in the cycle rsp_valid is high.
- Response data:
  - drsp_data captures mem_rdata on read completion; it is unchanged on write completion, but drsp_valid still pulses.
  - irsp_data captures mem_rdata on fetch completion.
  - Response data holds until the next capture.
- Flush:
  - iflush during I_BUSY, or in the same cycle as mem_ack in I_BUSY, sets flush_pend.
  - The memory transaction still completes, but irsp_valid is suppressed; irsp_data is still updated.
  - flush_pend clears on that completion.
  - iflush in IDLE or D_BUSY has no effect.
- mem_ack while IDLE is ignored.
- rst mid-transaction: immediate return to IDLE, mem_req = 0, no response pulse, streak cleared.

Optional Feature:
- Macro LC3_MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on acceptance and increments each busy cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, the state returns to IDLE, and the owner's rsp_valid and mem_err both pulse in the next cycle.
  - Response data is left unchanged.
- Undefined: no counter; the arbiter waits indefinitely; mem_err is tied 0.

Test Plan:
- Fetch only: ireq_valid, addr 16'h3000; mem_ack at T+1 with rdata 16'h1261 -> mem_req T+1 only, irsp_valid at T+2, irsp_data = 16'h1261, busy low at T+2.
- Simultaneous requests: ireq 16'h3001 and dreq read 16'h4000 -> data granted first; fetch granted in the cycle drsp_valid pulses.
- Starvation: ireq_valid held high, 6 back-to-back data reads, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,I,D.
- Store: dreq_we = 1, addr 16'h4010, wdata 16'hBEEF; mem_ack delayed 3 cycles -> mem_we/addr/wdata stable throughout, drsp_valid pulses once, drsp_data unchanged.
- Flush: fetch in flight, iflush pulsed before mem_ack -> no irsp_valid; the next fetch responds normally.
- Reset mid-transaction: rst during D_BUSY, then mem_ack -> mem_req 0 the cycle after rst, no drsp_valid, next fetch served normally. With LC3_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no mem_ack -> mem_err and drsp_valid pulse together.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Shares one single-ported LC-3 memory between the fetch and data ports.
// Define LC3_MEM_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES without mem_ack.
module lc3_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq_valid,
    input  logic [15:0] ireq_addr,
    output logic        ireq_ready,
    output logic        irsp_valid,
    output logic [15:0] irsp_data,
    input  logic        iflush,
    input  logic        dreq_valid,
    input  logic        dreq_we,
    input  logic [15:0] dreq_addr,
    input  logic [15:0] dreq_wdata,
    output logic        dreq_ready,
    output logic        drsp_valid,
    output logic [15:0] drsp_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        mem_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    localparam int SW = $clog2(MAX_DATA_STREAK + 2);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          flush_pend;
    logic          streak_full;
    logic          i_win;
    logic          d_win;
    logic          timeout;

    assign streak_full = (streak == SW'(MAX_DATA_STREAK));

    // Data has priority unless it has already won too many times in a row.
    always_comb begin
        i_win = 1'b0;
        d_win = 1'b0;
        if (state == IDLE) begin
            i_win = ireq_valid && (!dreq_valid || streak_full);
            d_win = dreq_valid && !i_win;
        end
    end

    assign ireq_ready = i_win;
    assign dreq_ready = d_win;
    assign busy       = (state != IDLE);

`ifdef LC3_MEM_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timeout = (state != IDLE) && !mem_ack &&
                     (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 16'h0000;
        end else if (i_win || d_win) begin
            wait_cnt <= 16'h0000;
        end else if ((state != IDLE) && !mem_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            irsp_valid <= 1'b0;
            drsp_valid <= 1'b0;
            irsp_data  <= 16'h0000;
            drsp_data  <= 16'h0000;
            streak     <= '0;
            flush_pend <= 1'b0;
        end else begin
            irsp_valid <= 1'b0;
            drsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_win) begin
                        state    <= I_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ireq_addr;
                        streak   <= '0;
                    end else if (d_win) begin
                        state     <= D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= dreq_we;
                        mem_addr  <= dreq_addr;
                        mem_wdata <= dreq_wdata;
                        if (!ireq_valid) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end
                end
                I_BUSY: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        irsp_data  <= mem_rdata;
                        irsp_valid <= !(flush_pend || iflush);
                        flush_pend <= 1'b0;
                    end else if (timeout) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        irsp_valid <= 1'b1;
                        flush_pend <= 1'b0;
                    end else if (iflush) begin
                        flush_pend <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        drsp_valid <= 1'b1;
                        if (!mem_we) begin
                            drsp_data <= mem_rdata;
                        end
                    end else if (timeout) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        drsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed and randomized checks of lc3_mem_arbiter against a transaction model.
// The timeout scenario is exercised only when LC3_MEM_TIMEOUT_EN is defined.
module tb_lc3_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [15:0] ireq_addr;
    logic        ireq_ready;
    logic        irsp_valid;
    logic [15:0] irsp_data;
    logic        iflush;
    logic        dreq_valid;
    logic        dreq_we;
    logic [15:0] dreq_addr;
    logic [15:0] dreq_wdata;
    logic        dreq_ready;
    logic        drsp_valid;
    logic [15:0] drsp_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        mem_err;

    always #5 clk = ~clk;

    lc3_mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .irsp_valid(irsp_valid), .irsp_data(irsp_data), .iflush(iflush),
        .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dreq_ready(dreq_ready),
        .drsp_valid(drsp_valid), .drsp_data(drsp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .mem_err(mem_err)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    logic [15:0] dev_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    // Transaction-level model: one outstanding transfer record plus response expectations.
    bit          m_busy, m_is_d, m_we, m_flush;
    bit          e_irsp, e_drsp, e_err;
    logic [15:0] m_addr, m_wdata, m_idata, m_ddata;
    int          m_streak, m_wait;

    bit ack_en     = 1'b1;
    bit rand_delay = 1'b0;
    int ack_delay  = 0;
    int ack_cnt    = 0;

    bit    g_i, g_d;
    int    n_irsp, n_drsp;
    int    g_i_cyc, g_d_cyc, drsp_cyc;
    string gseq;
    logic [15:0] hold;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_flush  = 1'b0;
        m_streak = 0;
        m_idata  = 16'h0000;
        m_ddata  = 16'h0000;
        e_irsp   = 1'b0;
        e_drsp   = 1'b0;
        e_err    = 1'b0;
    endtask

    task automatic model_edge(input bit pi, input bit pd);
        e_irsp = 1'b0;
        e_drsp = 1'b0;
        e_err  = 1'b0;
        if (m_busy && mem_ack && m_we) ref_mem[m_addr] = m_wdata;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (mem_ack) begin
                if (m_is_d) begin
                    e_drsp = 1'b1;
                    if (!m_we) m_ddata = ref_mem[m_addr];
                end else begin
                    e_irsp  = !(m_flush || iflush);
                    m_idata = ref_mem[m_addr];
                end
                m_busy  = 1'b0;
                m_flush = 1'b0;
            end else begin
                if (!m_is_d && iflush) m_flush = 1'b1;
`ifdef LC3_MEM_TIMEOUT_EN
                m_wait++;
                if (m_wait == TO) begin
                    m_busy  = 1'b0;
                    m_flush = 1'b0;
                    e_err   = 1'b1;
                    if (m_is_d) e_drsp = 1'b1;
                    else        e_irsp = 1'b1;
                end
`endif
            end
        end else if (pi) begin
            m_busy   = 1'b1;
            m_is_d   = 1'b0;
            m_we     = 1'b0;
            m_addr   = ireq_addr;
            m_streak = 0;
            m_wait   = 0;
        end else if (pd) begin
            m_busy   = 1'b1;
            m_is_d   = 1'b1;
            m_we     = dreq_we;
            m_addr   = dreq_addr;
            m_wdata  = dreq_wdata;
            m_wait   = 0;
            m_streak = ireq_valid ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
    endtask

    task automatic check_outputs();
        check("busy", busy, m_busy);
        check("mem_req", mem_req, m_busy);
        if (m_busy) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", mem_we, m_we);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("irsp_valid", irsp_valid, e_irsp);
        check("drsp_valid", drsp_valid, e_drsp);
        check("irsp_data", irsp_data, m_idata);
        check("drsp_data", drsp_data, m_ddata);
        check("mem_err", mem_err, e_err);
    endtask

    // Memory device: acks after ack_delay cycles of a held request.
    task automatic respond();
        mem_ack = 1'b0;
        if (mem_req && ack_en) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    dev_mem[mem_addr] = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = dev_mem[mem_addr];
                end
                ack_cnt = 0;
                if (rand_delay) ack_delay = $urandom_range(0, 4);
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    endtask

    task automatic tick();
        bit pi, pd;
        #1;
        pi = !m_busy && ireq_valid && (!dreq_valid || m_streak >= MAXS);
        pd = !m_busy && dreq_valid && !pi;
        check("ireq_ready", ireq_ready, pi);
        check("dreq_ready", dreq_ready, pd);
        g_i = ireq_ready && ireq_valid;
        g_d = dreq_ready && dreq_valid;
        if (g_i) g_i_cyc = cyc;
        if (g_d) g_d_cyc = cyc;
        model_edge(pi, pd);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
        if (irsp_valid) n_irsp++;
        if (drsp_valid) begin
            n_drsp++;
            drsp_cyc = cyc;
        end
        respond();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        iflush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ireq_valid = 1'b0; ireq_addr = 16'h0000; iflush = 1'b0;
        dreq_valid = 1'b0; dreq_we = 1'b0; dreq_addr = 16'h0000; dreq_wdata = 16'h0000;
        mem_rdata = 16'h0000; mem_ack = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            dev_mem[a] = 16'($urandom);
            ref_mem[a] = dev_mem[a];
        end
        dev_mem[16'h3000] = 16'h1261; ref_mem[16'h3000] = 16'h1261;
        dev_mem[16'h3010] = 16'h0E07; ref_mem[16'h3010] = 16'h0E07;
        dev_mem[16'h3011] = 16'h2A55; ref_mem[16'h3011] = 16'h2A55;
        model_reset();

        do_reset();
        check("rst mem_addr", mem_addr, 16'h0000);
        check("rst mem_wdata", mem_wdata, 16'h0000);
        check("rst mem_we", mem_we, 16'h0000);
        check("rst irsp_data", irsp_data, 16'h0000);

        // Fetch only, minimum latency
        ack_delay = 0;
        ireq_addr = 16'h3000; ireq_valid = 1'b1;
        tick();
        check("t1 grant", g_i, 1'b1);
        ireq_valid = 1'b0;
        check("t1 mem_req T+1", mem_req, 1'b1);
        tick();
        check("t1 mem_req T+2", mem_req, 1'b0);
        check("t1 irsp_valid", irsp_valid, 1'b1);
        check("t1 irsp_data", irsp_data, 16'h1261);
        check("t1 busy", busy, 1'b0);

        // Simultaneous requests
        ireq_addr = 16'h3001; ireq_valid = 1'b1;
        dreq_addr = 16'h4000; dreq_we = 1'b0; dreq_valid = 1'b1;
        g_i_cyc = -1; g_d_cyc = -1; drsp_cyc = -1;
        for (int k = 0; k < 20 && g_i_cyc < 0; k++) begin
            tick();
            if (g_d) dreq_valid = 1'b0;
            if (g_i) ireq_valid = 1'b0;
        end
        check("t2 data first", (g_d_cyc >= 0) && (g_d_cyc < g_i_cyc), 1'b1);
        check("t2 fetch with drsp", g_i_cyc == drsp_cyc, 1'b1);
        repeat (3) tick();

        // Starvation guard
        gseq = "";
        n_drsp = 0;
        ireq_addr = 16'h3002; ireq_valid = 1'b1;
        dreq_we = 1'b0; dreq_valid = 1'b1;
        for (int k = 0; k < 60 && gseq.len() < 6; k++) begin
            dreq_addr = 16'h4000 + 16'(n_drsp);
            tick();
            if (g_d) begin
                gseq = {gseq, "D"};
                n_drsp++;
                if (n_drsp == 6) dreq_valid = 1'b0;
            end
            if (g_i) begin
                gseq = {gseq, "I"};
                ireq_valid = 1'b0;
            end
        end
        n_chk++;
        assert (gseq == "DDDDID") n_pass++;
        else $error("FAIL t3 grant order: observed %s expected DDDDID", gseq);
        dreq_valid = 1'b0; ireq_valid = 1'b0;
        repeat (4) tick();

        // Store with delayed ack
        ack_delay = 3;
        hold = m_ddata;
        n_drsp = 0;
        dreq_we = 1'b1; dreq_addr = 16'h4010; dreq_wdata = 16'hBEEF; dreq_valid = 1'b1;
        tick();
        check("t4 grant", g_d, 1'b1);
        dreq_valid = 1'b0; dreq_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (mem_req) begin
                check("t4 mem_we", mem_we, 1'b1);
                check("t4 mem_addr", mem_addr, 16'h4010);
                check("t4 mem_wdata", mem_wdata, 16'hBEEF);
            end
            tick();
        end
        check("t4 drsp count", 16'(n_drsp), 16'd1);
        check("t4 drsp_data held", drsp_data, hold);
        check("t4 memory written", dev_mem[16'h4010], 16'hBEEF);

        // Flush of an in-flight fetch
        n_irsp = 0;
        ireq_addr = 16'h3010; ireq_valid = 1'b1;
        tick();
        check("t5 grant", g_i, 1'b1);
        ireq_valid = 1'b0;
        tick();
        iflush = 1'b1;
        tick();
        iflush = 1'b0;
        repeat (5) tick();
        check("t5 no irsp", 16'(n_irsp), 16'd0);
        check("t5 irsp_data updated", irsp_data, 16'h0E07);
        ack_delay = 0;
        ireq_addr = 16'h3011; ireq_valid = 1'b1;
        tick();
        ireq_valid = 1'b0;
        repeat (3) tick();
        check("t5 next fetch irsp", 16'(n_irsp), 16'd1);
        check("t5 next fetch data", irsp_data, 16'h2A55);

        // Reset in the middle of a data transaction
        ack_en = 1'b0;
        n_drsp = 0;
        hold = m_ddata;
        dreq_addr = 16'h4020; dreq_we = 1'b0; dreq_valid = 1'b1;
        tick();
        check("t6 grant", g_d, 1'b1);
        dreq_valid = 1'b0;
        tick();
        check("t6 busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 mem_req after rst", mem_req, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        ack_en = 1'b1;
        repeat (3) tick();
        check("t6 no drsp", 16'(n_drsp), 16'd0);
        check("t6 drsp_data reset", drsp_data, 16'h0000);
        n_irsp = 0;
        ireq_addr = 16'h3000; ireq_valid = 1'b1;
        tick();
        ireq_valid = 1'b0;
        repeat (3) tick();
        check("t6 fetch irsp", 16'(n_irsp), 16'd1);
        check("t6 fetch data", irsp_data, 16'h1261);

`ifdef LC3_MEM_TIMEOUT_EN
        ack_en = 1'b0;
        n_drsp = 0; drsp_cyc = -1; g_d_cyc = -1;
        dreq_addr = 16'h4030; dreq_we = 1'b0; dreq_valid = 1'b1;
        tick();
        dreq_valid = 1'b0;
        for (int k = 0; k < 20 && n_drsp == 0; k++) begin
            tick();
            if (drsp_valid) check("t7 mem_err with drsp", mem_err, 1'b1);
        end
        check("t7 drsp count", 16'(n_drsp), 16'd1);
        check("t7 timeout latency", drsp_cyc - g_d_cyc == TO + 1, 1'b1);
        ack_en = 1'b1;
        repeat (2) tick();
`endif

        // Randomized traffic
        rand_delay = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if (!ireq_valid || g_i) begin
                ireq_valid = ($urandom_range(0, 1) == 1);
                ireq_addr  = 16'h3000 + 16'($urandom_range(0, 15));
            end
            if (!dreq_valid || g_d) begin
                dreq_valid = ($urandom_range(0, 2) != 0);
                dreq_we    = ($urandom_range(0, 1) == 1);
                dreq_addr  = 16'h4000 + 16'($urandom_range(0, 7));
                dreq_wdata = 16'($urandom);
            end
            iflush = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; ireq_valid = 1'b0; dreq_valid = 1'b0; iflush = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
